// File: rtl/cbus_rr_arbiter_if.sv
// cbus request/response types and the bundle between the arbiter, its masters
// and the downstream port.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

interface cbus_rr_arbiter_if #(parameter int NUM_INPUTS = 4);
  import cbus_pkg::*;

  cbus_req_t  ireqs  [NUM_INPUTS];
  cbus_resp_t iresps [NUM_INPUTS];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  // master: the environment (CPU-side masters and downstream bridge)
  modport master (output ireqs, output oresp, input iresps, input oreq);
  // slave: the arbiter itself
  modport slave  (input ireqs, input oresp, output iresps, output oreq);
endinterface

// File: rtl/cbus_rr_arbiter.sv
// N-to-1 cbus arbiter, fixed-priority or round-robin, burst-granular grants.
// Optional response watchdog enabled with `define CBUS_ARB_WATCHDOG_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requests
// BUSY  | owner's burst forwarded downstream until ready && last
// DRAIN | one bubble cycle so the finished master can drop valid
module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rr_mode,
  cbus_rr_arbiter_if.slave      bus,
  output logic [NUM_INPUTS-1:0] grant,
  output logic                  busy,
  output logic [CNT_W-1:0]      beat_cnt,
  output logic                  timeout_err
);

  localparam int IDX_W = $clog2(NUM_INPUTS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W:0]   cand;
  logic             any_valid;
  logic             burst_done;
  logic             wd_hit;
  logic [IDX_W-1:0] owner_next;
  cbus_resp_t       resp_fwd;

  // Search order starts at rr_ptr in round-robin mode, at 0 otherwise.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = rr_mode ? ({1'b0, rr_ptr} + (IDX_W+1)'(k)) : (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_INPUTS))
        cand = cand - (IDX_W+1)'(NUM_INPUTS);
      if (!any_valid && bus.ireqs[cand[IDX_W-1:0]].valid) begin
        any_valid = 1'b1;
        winner    = cand[IDX_W-1:0];
      end
    end
  end

  assign burst_done = bus.oresp.ready && bus.oresp.last;
  assign owner_next = (owner == IDX_W'(NUM_INPUTS - 1)) ? '0 : owner + 1'b1;

`ifdef CBUS_ARB_WATCHDOG_EN
  logic [CNT_W-1:0] wd_cnt;

  // The abort cycle is the TIMEOUT-th consecutive BUSY cycle without ready.
  assign wd_hit = (state == S_BUSY) && !bus.oresp.ready &&
                  (wd_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    resp_fwd = bus.oresp;
    if (wd_hit) begin
      resp_fwd.ready = 1'b1;
      resp_fwd.last  = 1'b1;
      resp_fwd.data  = '0;
    end
  end

  always_comb begin
    bus.oreq = (state == S_BUSY) ? bus.ireqs[owner] : '0;
    for (int k = 0; k < NUM_INPUTS; k++)
      bus.iresps[k] = ((state == S_BUSY) && (owner == IDX_W'(k))) ? resp_fwd : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
`ifdef CBUS_ARB_WATCHDOG_EN
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            owner    <= winner;
            grant    <= NUM_INPUTS'(1) << winner;
            beat_cnt <= '0;
            busy     <= 1'b1;
            state    <= S_BUSY;
`ifdef CBUS_ARB_WATCHDOG_EN
            wd_cnt   <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (bus.oresp.ready && (beat_cnt != '1))
            beat_cnt <= beat_cnt + 1'b1;
`ifdef CBUS_ARB_WATCHDOG_EN
          wd_cnt <= bus.oresp.ready ? '0 : wd_cnt + 1'b1;
          if (wd_hit)
            timeout_err <= 1'b1;
`endif
          if (burst_done) begin
            rr_ptr <= owner_next;
            grant  <= '0;
            busy   <= 1'b0;
            state  <= S_DRAIN;
          end else if (wd_hit) begin
            grant  <= '0;
            busy   <= 1'b0;
            state  <= S_DRAIN;
          end
        end
        S_DRAIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Randomized directed bench for cbus_rr_arbiter against a behavioural arbitration model.
// Covers the watchdog abort when built with CBUS_ARB_WATCHDOG_EN.
module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int TO = 10;

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          rr_mode = 1'b0;
  logic [N-1:0]  grant;
  logic          busy;
  logic [CW-1:0] beat_cnt;
  logic          timeout_err;

  cbus_rr_arbiter_if #(.NUM_INPUTS(N)) bus ();

  cbus_rr_arbiter #(.NUM_INPUTS(N), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .rr_mode     (rr_mode),
    .bus         (bus),
    .grant       (grant),
    .busy        (busy),
    .beat_cnt    (beat_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_ptr    = 0;
  logic       m_terr   = 1'b0;
  cbus_req_t  req_drv [N];
  cbus_resp_t resp_drv;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] mask, input logic mode, input int ptr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = mode ? (ptr + k) % N : k;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  function automatic int sat(input int v);
    return (v > (2**CW - 1)) ? (2**CW - 1) : v;
  endfunction

  task automatic drive_reqs(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      req_drv[i] = '{valid: mask[i], is_write: 1'($urandom), size: 3'($urandom),
                     addr: $urandom, strb: 4'($urandom), data: $urandom};
      bus.ireqs[i] = req_drv[i];
    end
  endtask

  task automatic drive_resp(input logic rdy, input logic lst);
    resp_drv  = '{ready: rdy, last: lst, data: $urandom};
    bus.oresp = resp_drv;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_grant"}, 128'(grant), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_oreq"}, 128'(bus.oreq), 128'(0));
    check({tag, "_terr"}, 128'(timeout_err), 128'(m_terr));
    for (int k = 0; k < N; k++)
      check({tag, "_iresp"}, 128'(bus.iresps[k]), 128'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_reqs('0);
    drive_resp(1'($urandom), 1'($urandom));
    tick();
    m_ptr  = 0;
    m_terr = 1'b0;
    check_quiet("rst");
    check("rst_beat", 128'(beat_cnt), 128'(0));
    reset = 1'b0;
  endtask

  // Starts and ends just after an edge with the arbiter in IDLE.
  task automatic do_grant(input logic [N-1:0] mask, input logic mode, input int beats,
                          input int rdy_pct, input int rst_beat);
    int         w;
    int         got;
    int         stalls;
    logic       rdy;
    logic       lst;
    cbus_resp_t exp_r;
    rr_mode = mode;
    drive_reqs(mask);
    drive_resp(1'($urandom), 1'($urandom));
    #1;
    check_quiet("idle");
    w = pick(mask, mode, m_ptr);
    tick();
    if (w < 0) begin
      check("idle_stay", 128'(busy), 128'(0));
      return;
    end
    check("grant", 128'(grant), 128'(onehot(w)));
    check("busy", 128'(busy), 128'(1));
    check("beat_clr", 128'(beat_cnt), 128'(0));
    got    = 0;
    stalls = 0;
    while (got < beats) begin
      rdy    = (stalls >= 3) || ($urandom_range(1, 100) <= rdy_pct);
      lst    = rdy ? (got == beats - 1) : 1'($urandom);
      stalls = rdy ? 0 : stalls + 1;
      drive_resp(rdy, lst);
      if ($urandom_range(0, 3) == 0) begin
        req_drv[w].valid = 1'b0;
        bus.ireqs[w]     = req_drv[w];
      end
      rr_mode = 1'($urandom);
      #1;
      check("oreq", 128'(bus.oreq), 128'(req_drv[w]));
      for (int k = 0; k < N; k++) begin
        exp_r = (k == w) ? resp_drv : '0;
        check("iresp", 128'(bus.iresps[k]), 128'(exp_r));
      end
      if (rst_beat > 0 && got == rst_beat - 1) begin
        reset = 1'b1;
        tick();
        m_ptr  = 0;
        m_terr = 1'b0;
        check_quiet("midrst");
        check("midrst_beat", 128'(beat_cnt), 128'(0));
        reset = 1'b0;
        drive_reqs('0);
        return;
      end
      tick();
      if (rdy) got++;
      if (got < beats) begin
        check("grant_hold", 128'(grant), 128'(onehot(w)));
        check("busy_hold", 128'(busy), 128'(1));
        check("beat_cnt", 128'(beat_cnt), 128'(sat(got)));
      end
    end
    m_ptr = (w + 1) % N;
    drive_resp(1'($urandom), 1'($urandom));
    #1;
    check_quiet("drain");
    check("beat_final", 128'(beat_cnt), 128'(sat(got)));
    tick();
  endtask

  task automatic stall_test();
    int         stall_len;
    cbus_resp_t exp_r;
    rr_mode = 1'b0;
    drive_reqs(4'b0010);
    drive_resp(1'b0, 1'b0);
    #1;
    check_quiet("wd_idle");
    tick();
    check("wd_grant", 128'(grant), 128'(4'b0010));
`ifdef CBUS_ARB_WATCHDOG_EN
    stall_len = TO;
`else
    stall_len = 3 * TO;
`endif
    for (int c = 1; c <= stall_len; c++) begin
      drive_resp(1'b0, 1'($urandom));
      #1;
      exp_r = resp_drv;
`ifdef CBUS_ARB_WATCHDOG_EN
      if (c == TO) exp_r = '{ready: 1'b1, last: 1'b1, data: '0};
`endif
      check("wd_resp", 128'(bus.iresps[1]), 128'(exp_r));
      tick();
      if (c < stall_len) begin
        check("wd_busy", 128'(busy), 128'(1));
        check("wd_terr_low", 128'(timeout_err), 128'(0));
      end
    end
`ifdef CBUS_ARB_WATCHDOG_EN
    m_terr = 1'b1;
    drive_reqs('0);
    drive_resp(1'b0, 1'b0);
    #1;
    check_quiet("wd_drain");
    tick();
    check_quiet("wd_back_idle");
    tick();
    check_quiet("wd_sticky");
`else
    check("wd_still_busy", 128'(busy), 128'(1));
    check("wd_no_terr", 128'(timeout_err), 128'(0));
    drive_resp(1'b1, 1'b1);
    tick();
    m_ptr = 2;
    drive_reqs('0);
    #1;
    check_quiet("wd_drain");
    tick();
`endif
  endtask

  initial begin
    drive_reqs('0);
    drive_resp(1'b0, 1'b0);
    tick();
    do_reset();

    // single master, 4 beats at full rate; rr_ptr -> 3
    do_grant(4'b0100, 1'b0, 4, 100, 0);
    // wrap: ptr 3, only master 1 -> granted; ptr -> 2, then full mask picks 2
    do_grant(4'b0010, 1'b1, 2, 100, 0);
    do_grant(4'b1111, 1'b1, 1, 100, 0);

    // fixed priority: master 0 always beats master 3
    for (int i = 0; i < 4; i++)
      do_grant(4'b1001, 1'b0, $urandom_range(1, 3), 80, 0);

    // round-robin from a clean pointer: 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 5; i++)
      do_grant(4'b1111, 1'b1, 1, 100, 0);

    for (int i = 0; i < 40; i++)
      do_grant(4'($urandom_range(0, 15)), 1'($urandom), $urandom_range(1, 5), 70, 0);

    // beat counter saturates at all-ones
    do_grant(4'b0001, 1'b1, 20, 100, 0);

    // reset during beat 2 of 8
    do_grant(4'b1000, 1'b0, 8, 100, 2);
    do_grant(4'b1111, 1'b1, 1, 100, 0);

    stall_test();
    do_grant(4'b0100, 1'b1, 2, 100, 0);
    do_reset();
    do_grant(4'b1111, 1'b1, 1, 100, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
